// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-port register file and its clear sequencer.
package reg_file_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } seq_state_e;

  // Byte-lane merge: take the new byte when its enable is set, else keep the old one.
  function automatic logic [7:0] merge(input logic [7:0] old_b,
                                       input logic [7:0] new_b,
                                       input logic       be);
    return be ? new_b : old_b;
  endfunction

  function automatic bit cfg_legal(input int num_rd, input int data_width);
    return (num_rd >= 1) && (num_rd <= 4) && (data_width > 0) && ((data_width % 8) == 0);
  endfunction

endpackage

// File: rtl/reg_file_clr_seq.sv
// Post-reset clear sequencer: sweeps every entry to zero, then raises ready and stays in RUN.
module reg_file_clr_seq
  import reg_file_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  output logic                  ready,
  output logic                  wr_drop,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output seq_state_e            state_dbg
);

  seq_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  ready_q, ready_d;
  logic                  wr_drop_q, wr_drop_d;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    wr_drop_d = 1'b0;
    if (state_q == CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      wr_drop_d = wr_en;
      // The last entry is written on this edge, so the array is fully zeroed in RUN.
      if (&clr_cnt_q) state_d = RUN;
    end
    ready_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  assign ready     = ready_q;
  assign wr_drop   = wr_drop_q;
  assign clr_we    = (state_q == CLEAR);
  assign clr_addr  = clr_cnt_q;
  assign state_dbg = state_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD combinational reads, one byte-enabled write,
// optional bypass and hardwired zero entry, plus a registered watch-window flag.
// Write handshake: wr_en is a one-cycle request; it commits at the edge only when
// ready=1 and at least one byte enable is set, and is never back-pressured.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1,
  parameter int WATCH_LO   = 13,
  parameter int WATCH_HI   = 14
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic [DATA_WIDTH/8-1:0]        wr_be,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
  output logic                           ready,
  output logic                           watch_hit,
  output logic                           wr_drop
);

  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int NBYTES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] WIN_LO = ADDR_WIDTH'(WATCH_LO);
  localparam logic [ADDR_WIDTH-1:0] WIN_HI = ADDR_WIDTH'(WATCH_HI);

  if (!cfg_legal(NUM_RD, DATA_WIDTH)) begin : g_bad_cfg
    $error("reg_file_mp: NUM_RD must be 1..4 and DATA_WIDTH a multiple of 8");
  end

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  seq_state_e            seq_state;

  reg_file_clr_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_clr_seq (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .ready     (ready),
    .wr_drop   (wr_drop),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .state_dbg (seq_state)
  );

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  run;
  logic                  commit;
  logic [DATA_WIDTH-1:0] wr_merged;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  watch_hit_q, watch_hit_d;

  assign run    = (seq_state == RUN);
  assign commit = run && wr_en && (|wr_be) && !(ZERO_REG && (wr_addr == '0));

  always_comb begin
    wr_merged = mem_q[wr_addr];
    for (int b = 0; b < NBYTES; b++) begin
      wr_merged[8*b +: 8] = merge(mem_q[wr_addr][8*b +: 8], wr_data[8*b +: 8], wr_be[b]);
    end
  end

  // Sweep and commit are mutually exclusive: commits need RUN, the sweep only runs in CLEAR.
  always_comb begin
    mem_we    = clr_we || commit;
    mem_waddr = clr_we ? clr_addr : wr_addr;
    mem_wdata = clr_we ? '0 : wr_merged;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    logic [ADDR_WIDTH-1:0] ra;
    ra      = '0;
    rd_data = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      if (!run || (ZERO_REG && (ra == '0))) begin
        rd_data[k*DATA_WIDTH +: DATA_WIDTH] = '0;
      end else if (BYPASS && commit && (wr_addr == ra)) begin
        rd_data[k*DATA_WIDTH +: DATA_WIDTH] = wr_merged;
      end else begin
        rd_data[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[ra];
      end
    end
  end

  assign watch_hit_d = commit && (wr_addr >= WIN_LO) && (wr_addr <= WIN_HI);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) watch_hit_q <= 1'b0;
    else       watch_hit_q <= watch_hit_d;
  end

  assign watch_hit = watch_hit_q;

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port register file for the RISC-V core and its coprocessor variants. It has NUM_RD combinational read ports and one synchronous byte-enabled write port, with optional write-to-read bypass and an optional hardwired-zero entry. After every reset, a built-in clear sequencer zeroes all entries, and a registered watch flag reports committed writes to a configurable address window.

## Interface
- DATA_WIDTH, 32, entry width in bits; must be a multiple of 8
- ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH entries
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1: entry 0 reads 0 and ignores writes
- BYPASS, 1, 1: a same-cycle write is forwarded to matching read ports
- WATCH_LO / WATCH_HI, 13 / 14, inclusive address window for watch_hit
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  write request
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- wr_be  in  DATA_WIDTH/8  byte enables; bit i covers wr_data[8i+7:8i]
- rd_addr  in  NUM_RD*ADDR_WIDTH  read addresses; port k uses slice k
- rd_data  out  NUM_RD*DATA_WIDTH  read data; port k uses slice k
- ready  out  1  clear sequence finished; writes are accepted
- watch_hit  out  1  registered pulse for a committed write inside [WATCH_LO, WATCH_HI]
- wr_drop  out  1  registered pulse for a wr_en rejected while ready=0

## Operation
- Sequencer states:
  - CLEAR: entered asynchronously on reset. clr_cnt starts at 0. Each clock writes 0 to entry clr_cnt and increments clr_cnt. After the write to DEPTH-1, the state moves to RUN.
  - RUN: normal operation. The only exit is reset.
- ready = (state == RUN). It is a registered output.
- Commit: occurs in RUN when wr_en=1, wr_be≠0 and not (ZERO_REG && wr_addr==0). Each byte with wr_be[i]=1 is replaced; all other bytes are kept.
- wr_en=1 with wr_be=0, or a write to entry 0 with ZERO_REG=1: no commit, no watch_hit, no wr_drop.
- Read port k:
  - Returns 0 if ready=0.
  - Returns 0 if ZERO_REG and rd_addr_k==0.
  - If BYPASS, a commit is pending this cycle, and wr_addr==rd_addr_k: returns the byte-merge of wr_data over the stored entry.
  - Otherwise returns the stored entry.
- All ports are independent. Any number of ports may address the same entry.
- watch_hit: set at the edge of a commit with WATCH_LO ≤ wr_addr ≤ WATCH_HI, for one cycle.
- wr_drop: set at the edge where wr_en=1 and state=CLEAR, for one cycle.
- Reset mid-operation: in-flight writes are lost, the sweep restarts from address 0, and no partial state survives after ready rises again.

## Timing
- Reset values: ready=0, watch_hit=0, wr_drop=0, rd_data=0 (forced by ready=0), state=CLEAR, clr_cnt=0.
- The sweep takes exactly DEPTH rising edges after reset deasserts. ready reads 1 after the DEPTH-th edge; 32 cycles for ADDR_WIDTH=5.
- Write latency: the data is visible on a non-bypassed read in the cycle after the commit edge. With BYPASS=1 it is visible combinationally in the same cycle.
- watch_hit and wr_drop: 1-cycle latency from the triggering edge; width is exactly one cycle per event.
- Back-to-back commits are permitted every cycle. Consecutive watch commits hold watch_hit high continuously.
- Array contents have no reset. Only the sweep initialises them.

## Structure
- Shared package reg_file_pkg:
  - State enum {CLEAR, RUN}.
  - Byte-merge function merge(old, new, be).
  - NUM_RD and DATA_WIDTH%8 legality checks, as elaboration-time assertions.
- Sub-module reg_file_clr_seq: owns state, clr_cnt, ready and wr_drop; exports the clear-write strobe and address.
- The top level owns the array, the read muxes, the bypass and watch_hit.

## Test plan
- Reset and sweep: pre-load garbage via a backdoor, pulse reset → ready=0 for 32 edges, then 1; all 32 entries read 0.
- Byte write: write 0xA5A5A5A5 to x5 with be=4'hF, then 0x0000BEEF with be=4'b0011 → x5 reads 0xA5A5BEEF on the next cycle.
- Bypass and zero register: wr_en to x7 = 0x12345678 while rd_addr0=7 → rd_data0=0x12345678 in the same cycle. Write to x0 → x0 reads 0, watch_hit=0.
- Watch window: commits to x12, x13, x14, x15 on consecutive cycles → watch_hit = 0, 1, 1, 0 on the following cycles.
- Drop during clear: wr_en=1 to x3 at sweep cycle 4 → wr_drop pulses one cycle; x3 reads 0 after ready.
- Reset mid-run: assert reset asynchronously between edges after writing x9=0xFFFFFFFF → ready falls immediately; after 32 edges x9 reads 0.
